alu_pe_share_arb: RTL and testbench
===================================

# alu_pe_share_arb

Arbiter that shares one multi-cycle ALU processing element (e.g. a dot8 or muldiv unit) between `NUM_REQS` ALU blocks. Round-robin issue with grant lock under backpressure, outstanding-request credit limiting, and in-order response routing back to the issuing block via an order FIFO. Sits between the per-block PE switches and a single shared PE instance, replacing per-block PE copies when area matters more than throughput.

## Interface
- `NUM_REQS`, 4, number of requesting ALU blocks (≥2)
- `DATA_W`, 64, request payload width (operands + op + tag as packed by requester)
- `RSP_W`, 32, response payload width
- `MAX_INFLIGHT`, 8, max outstanding PE requests (power of 2, ≥2)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQS  per-block request valid
- `req_data`  in  NUM_REQS*DATA_W  per-block payload, block i at [i*DATA_W +: DATA_W]
- `req_ready`  out  NUM_REQS  per-block accept
- `pe_req_valid`  out  1  request to shared PE
- `pe_req_data`  out  DATA_W  granted payload
- `pe_req_ready`  in  1  PE accept
- `pe_rsp_valid`  in  1  PE response valid (PE is strictly in-order)
- `pe_rsp_data`  in  RSP_W  PE response payload
- `pe_rsp_ready`  out  1  response accept
- `rsp_valid`  out  NUM_REQS  one-hot response valid to owning block
- `rsp_data`  out  RSP_W  response payload, shared by all blocks
- `rsp_ready`  in  NUM_REQS  per-block response accept
- `inflight`  out  CLOG2(MAX_INFLIGHT)+1  outstanding request count

## Operation
- Fire = valid & ready on a channel.
- Issue: `can_issue` = inflight < MAX_INFLIGHT. When unlocked, grant = first i with req_valid[i], searching from `rr_ptr` upward with wrap. `pe_req_valid` = can_issue & any req_valid; `pe_req_data` = granted payload; `req_ready[g]` = pe_req_ready & can_issue for grantee only, 0 elsewhere.
- Grant lock: pe_req_valid & !pe_req_ready registers `locked`=1 and `lock_idx`=grant; next cycle grant forced to lock_idx regardless of other requesters. Lock clears on pe_req fire. Requesters hold valid and data stable until fire (codebase handshake rule).
- On pe_req fire: `rr_ptr` ← grant+1 mod NUM_REQS; grant index pushed into order FIFO; inflight +1.
- Response: head = order FIFO head. `rsp_valid[head]` = pe_rsp_valid & fifo non-empty; `rsp_data` = pe_rsp_data; `pe_rsp_ready` = rsp_ready[head] & fifo non-empty. On fire: pop FIFO, inflight −1.
- Simultaneous req fire and rsp fire: inflight unchanged, FIFO push and pop both take effect.
- Full: inflight == MAX_INFLIGHT → pe_req_valid=0, all req_ready=0, even if a response fires that cycle (no rsp→req combinational path).
- pe_rsp_valid with empty FIFO: protocol error; pe_rsp_ready=0, all rsp_valid=0, simulation assertion fires.
- Order FIFO depth = MAX_INFLIGHT, so it never overflows while credit rule holds.

## Timing
- Request path fully combinational: req → pe_req same cycle, zero added latency.
- Response path combinational: pe_rsp → rsp same cycle.
- Grant decision uses registered rr_ptr/locked only.
- Reset (asserted low, async): rr_ptr=0, locked=0, inflight=0, FIFO empty; outputs pe_req_valid=0, req_ready=0, pe_rsp_ready=0, rsp_valid=0, inflight=0; pe_req_data/rsp_data don't-care. Reset mid-operation drops all outstanding tracking; PE must be reset together.

## Configuration
- `ALU_PE_SHARE_ARB_PERF_EN`: when defined, adds outputs `perf_stall_cycles` (64b, cycles with any req_valid but no pe_req fire) and `perf_issued` (64b, pe_req fires), both reset to 0, wrapping. When undefined, ports and counters absent; functional behaviour identical.

## Structure
- Shared package: `ALU_ARB_IDX_W` = CLOG2(NUM_REQS) helper typedef for requester index, perf counter width constant.
- One sub-module: `alu_pe_share_order_fifo` (depth MAX_INFLIGHT, width ALU_ARB_IDX_W, push/pop/empty/full, head output unregistered, async active-low reset).
- Round-robin search inline in this block.

## Test plan
- Fairness: all 4 blocks hold req_valid, pe_req_ready=1 → grants 0,1,2,3,0 on consecutive cycles; rsp returned to blocks in same order.
- Lock: block 2 granted, pe_req_ready=0 for 3 cycles while block 1 raises valid → grant stays 2, pe_req_data unchanged, block 2 fires cycle 4, next grant 3.
- Credit: MAX_INFLIGHT=8, PE never responds → exactly 8 fires, inflight=8, then pe_req_valid=0; one rsp fire → inflight=7, issue resumes next cycle.
- Routing backpressure: head owner 1 with rsp_ready[1]=0 → rsp_valid=4'b0010, pe_rsp_ready=0 until ready, other blocks never see valid.
- Simultaneous: inflight=5, req and rsp fire same cycle → inflight stays 5, FIFO order preserved.
- Reset: assert reset low with inflight=3 and locked=1 → all outputs 0 asynchronously, after release first grant is block 0.

Source files
------------

// File: rtl/alu_pe_share_arb_pkg.sv
// Shared types and constants for the ALU processing-element sharing arbiter.
// Holds the requester-index width helper and the perf counter width.
package alu_pe_share_arb_pkg;

    localparam int ALU_ARB_PERF_W = 64;

    typedef logic [ALU_ARB_PERF_W-1:0] alu_arb_perf_t;

    // Requester index width; at least one bit so a 1-wide index is always legal.
    function automatic int alu_arb_idx_w(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

endpackage

// File: rtl/alu_pe_share_order_fifo.sv
// Order FIFO recording which requester owns each outstanding PE request.
// Head is read straight from storage so routing is combinational.
module alu_pe_share_order_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_idx,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_idx;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_pe_share_arb.sv
// Shares one in-order multi-cycle ALU PE between NUM_REQS blocks: round-robin issue,
// grant lock under backpressure, credit limit, in-order response routing.
// Optional perf counters: define ALU_PE_SHARE_ARB_PERF_EN.
module alu_pe_share_arb
    import alu_pe_share_arb_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATA_W       = 64,
    parameter int RSP_W        = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid,
    input  logic [NUM_REQS*DATA_W-1:0]   req_data,
    output logic [NUM_REQS-1:0]          req_ready,
    output logic                         pe_req_valid,
    output logic [DATA_W-1:0]            pe_req_data,
    input  logic                         pe_req_ready,
    input  logic                         pe_rsp_valid,
    input  logic [RSP_W-1:0]             pe_rsp_data,
    output logic                         pe_rsp_ready,
    output logic [NUM_REQS-1:0]          rsp_valid,
    output logic [RSP_W-1:0]             rsp_data,
    input  logic [NUM_REQS-1:0]          rsp_ready,
    output logic [$clog2(MAX_INFLIGHT):0] inflight
`ifdef ALU_PE_SHARE_ARB_PERF_EN
   ,output logic [ALU_ARB_PERF_W-1:0]    perf_stall_cycles,
    output logic [ALU_ARB_PERF_W-1:0]    perf_issued
`endif
);
    localparam int ALU_ARB_IDX_W = alu_arb_idx_w(NUM_REQS);
    localparam int CNT_W         = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [ALU_ARB_IDX_W-1:0] rr_ptr, lock_idx, rr_grant, grant, cand, head;
    logic                     locked, can_issue, any_valid, head_ready;
    logic                     req_fire, rsp_fire, fifo_empty, fifo_full;

    assign any_valid = |req_valid;
    assign can_issue = (inflight < MAX_CNT);

    // Reverse scan so the nearest valid requester at/after rr_ptr wins.
    always_comb begin
        rr_grant = rr_ptr;
        cand     = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            cand = ALU_ARB_IDX_W'((int'(rr_ptr) + k) % NUM_REQS);
            if (req_valid[cand]) rr_grant = cand;
        end
    end

    assign grant = locked ? lock_idx : rr_grant;

    always_comb begin
        pe_req_data = '0;
        req_ready   = '0;
        rsp_valid   = '0;
        head_ready  = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant == ALU_ARB_IDX_W'(i)) begin
                pe_req_data  = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = reset && can_issue && any_valid && pe_req_ready;
            end
            if (head == ALU_ARB_IDX_W'(i)) begin
                rsp_valid[i] = reset && pe_rsp_valid && !fifo_empty;
                head_ready   = rsp_ready[i];
            end
        end
    end

    assign pe_req_valid = reset && can_issue && any_valid;
    assign req_fire     = pe_req_valid && pe_req_ready;
    assign pe_rsp_ready = reset && !fifo_empty && head_ready;
    assign rsp_fire     = pe_rsp_valid && pe_rsp_ready;
    assign rsp_data     = pe_rsp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            inflight <= '0;
        end else begin
            if (req_fire) begin
                locked <= 1'b0;
                rr_ptr <= (grant == ALU_ARB_IDX_W'(NUM_REQS - 1)) ? '0 : grant + 1'b1;
            end else if (pe_req_valid) begin
                locked   <= 1'b1;
                lock_idx <= grant;
            end
            case ({req_fire, rsp_fire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    alu_pe_share_order_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ALU_ARB_IDX_W)
    ) u_order_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_fire),
        .push_idx (grant),
        .pop      (rsp_fire),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

`ifdef ALU_PE_SHARE_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_issued       <= '0;
        end else begin
            if (any_valid && !req_fire) perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (req_fire)               perf_issued       <= perf_issued + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(pe_rsp_valid && fifo_empty))
                else $error("alu_pe_share_arb: PE response with no outstanding request");
            assert (!(req_fire && fifo_full))
                else $error("alu_pe_share_arb: issue with order FIFO full");
        end
    end
`endif

endmodule

// File: tb/tb_alu_pe_share_arb.sv
// Directed bench for alu_pe_share_arb: fairness, lock, credit, routing, simultaneous fire, reset.
module tb_alu_pe_share_arb;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int RW = 32;
    localparam int MI = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            pe_req_valid;
    logic [DW-1:0]   pe_req_data;
    logic            pe_req_ready;
    logic            pe_rsp_valid;
    logic [RW-1:0]   pe_rsp_data;
    logic            pe_rsp_ready;
    logic [N-1:0]    rsp_valid;
    logic [RW-1:0]   rsp_data;
    logic [N-1:0]    rsp_ready;
    logic [$clog2(MI):0] inflight;

    int checks = 0;
    int errors = 0;
    int ord [5] = '{1, 2, 3, 0, 2};

    always #5 clk = ~clk;

    alu_pe_share_arb #(.NUM_REQS(N), .DATA_W(DW), .RSP_W(RW), .MAX_INFLIGHT(MI)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .pe_req_valid (pe_req_valid),
        .pe_req_data  (pe_req_data),
        .pe_req_ready (pe_req_ready),
        .pe_rsp_valid (pe_rsp_valid),
        .pe_rsp_data  (pe_rsp_data),
        .pe_rsp_ready (pe_rsp_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .inflight     (inflight)
    );

    function automatic logic [63:0] dv(input int i);
        return 64'hCAFE_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = '0;
        pe_req_ready = 1'b0;
        pe_rsp_valid = 1'b0;
        pe_rsp_data  = '0;
        rsp_ready    = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dv(i);

        // Reset holds every handshake output low even with active inputs.
        tick(); tick();
        req_valid = 4'hF; pe_req_ready = 1'b1; rsp_ready = 4'hF; pe_rsp_valid = 1'b1;
        #1;
        chk("rst_pe_req_valid", 64'(pe_req_valid), 64'h0);
        chk("rst_req_ready",    64'(req_ready),    64'h0);
        chk("rst_pe_rsp_ready", 64'(pe_rsp_ready), 64'h0);
        chk("rst_rsp_valid",    64'(rsp_valid),    64'h0);
        chk("rst_inflight",     64'(inflight),     64'h0);
        pe_rsp_valid = 1'b0; req_valid = '0;
        tick();
        reset = 1'b1;

        // Fairness: grants 0,1,2,3,0.
        req_valid = 4'hF; pe_req_ready = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("fair_grant", 64'(req_ready), 64'(1 << (c % 4)));
            chk("fair_data",  64'(pe_req_data), dv(c % 4));
            tick();
        end
        chk("fair_inflight", 64'(inflight), 64'd5);

        // Simultaneous issue (block 2) and response (head block 0).
        req_valid = 4'b0100; pe_rsp_valid = 1'b1; pe_rsp_data = 32'h5000_0000;
        #1;
        chk("sim_req_ready", 64'(req_ready), 64'h4);
        chk("sim_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("sim_rsp_data",  64'(rsp_data),  64'h5000_0000);
        tick();
        chk("sim_inflight", 64'(inflight), 64'd5);

        // Drain in issue order: 1,2,3,0,2.
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            pe_rsp_data = 32'h5000_0001 + 32'(k);
            #1;
            chk("order_rsp_valid", 64'(rsp_valid), 64'(1 << ord[k]));
            chk("order_rsp_data",  64'(rsp_data),  64'(32'h5000_0001 + 32'(k)));
            chk("order_pe_ready",  64'(pe_rsp_ready), 64'h1);
            tick();
        end
        pe_rsp_valid = 1'b0;
        #1;
        chk("drain_inflight", 64'(inflight), 64'd0);

        // Routing backpressure: head owner 1 while block 1 not ready.
        req_valid = 4'b0010;
        #1;
        chk("rt_issue", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0; pe_rsp_valid = 1'b1; pe_rsp_data = 32'h6000_0001; rsp_ready = 4'b1101;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk("rt_rsp_valid", 64'(rsp_valid),    64'h2);
            chk("rt_pe_ready",  64'(pe_rsp_ready), 64'h0);
            tick();
        end
        chk("rt_inflight_hold", 64'(inflight), 64'd1);
        rsp_ready = 4'hF;
        #1;
        chk("rt_pe_ready_go", 64'(pe_rsp_ready), 64'h1);
        tick();
        pe_rsp_valid = 1'b0;
        #1;
        chk("rt_inflight_done", 64'(inflight), 64'd0);

        // Lock: block 2 stalled 3 cycles while block 1 joins.
        req_valid = 4'b0100; pe_req_ready = 1'b0;
        #1;
        chk("lk_valid", 64'(pe_req_valid), 64'h1);
        chk("lk_ready", 64'(req_ready),    64'h0);
        tick();
        req_valid = 4'b0110;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk("lk_hold_data", 64'(pe_req_data), dv(2));
            tick();
        end
        pe_req_ready = 1'b1;
        #1;
        chk("lk_fire_ready", 64'(req_ready),   64'h4);
        chk("lk_fire_data",  64'(pe_req_data), dv(2));
        tick();
        req_valid = 4'b1010;
        #1;
        chk("lk_next_grant", 64'(req_ready), 64'h8);
        tick();

        // Lock beats priority: block 0 joins behind a stalled block 1 with rr_ptr at 0.
        req_valid = 4'b0010; pe_req_ready = 1'b0;
        tick();
        req_valid = 4'b0011;
        #1;
        chk("lk_pri_data", 64'(pe_req_data), dv(1));
        pe_req_ready = 1'b1;
        #1;
        chk("lk_pri_ready", 64'(req_ready), 64'h2);
        tick();

        // Build inflight=3 with a live lock on block 0, then reset asynchronously.
        req_valid = 4'b0001; pe_req_ready = 1'b0;
        tick();
        chk("rs_pre_inflight", 64'(inflight), 64'd3);
        pe_req_ready = 1'b1; pe_rsp_valid = 1'b1; rsp_ready = 4'hF; reset = 1'b0;
        #1;
        chk("rs_pe_req_valid", 64'(pe_req_valid), 64'h0);
        chk("rs_req_ready",    64'(req_ready),    64'h0);
        chk("rs_pe_rsp_ready", 64'(pe_rsp_ready), 64'h0);
        chk("rs_rsp_valid",    64'(rsp_valid),    64'h0);
        chk("rs_inflight",     64'(inflight),     64'h0);
        pe_rsp_valid = 1'b0;
        tick();
        reset = 1'b1; req_valid = 4'hF;
        #1;
        chk("rs_first_data", 64'(pe_req_data), dv(0));

        // Credit: exactly 8 issues, then stall until a response frees a slot.
        for (int c = 0; c < 8; c++) begin
            chk("cr_grant", 64'(req_ready), 64'(1 << (c % 4)));
            tick();
        end
        chk("cr_inflight_full", 64'(inflight),     64'd8);
        chk("cr_valid_full",    64'(pe_req_valid), 64'h0);
        chk("cr_ready_full",    64'(req_ready),    64'h0);
        pe_rsp_valid = 1'b1; pe_rsp_data = 32'h7000_0000;
        #1;
        chk("cr_no_rsp_path", 64'(pe_req_valid), 64'h0);
        chk("cr_rsp_valid",   64'(rsp_valid),    64'h1);
        tick();
        pe_rsp_valid = 1'b0;
        #1;
        chk("cr_inflight_free", 64'(inflight),     64'd7);
        chk("cr_resume_valid",  64'(pe_req_valid), 64'h1);
        chk("cr_resume_grant",  64'(req_ready),    64'h1);
        tick();
        chk("cr_inflight_refill", 64'(inflight), 64'd8);

        req_valid = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
